// File: rtl/kick_scheduler.sv
// Kicker sequencer: charge, ready/arbitration between host (A) and auto-kick (B),
// timed fire strobe, post-kick cooldown and sticky charge-timeout fault.
module kick_scheduler #(
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned CHARGE_TIMEOUT = 3000,
    parameter int unsigned COOLDOWN_MS    = 200,
    parameter int unsigned KS_HOLD        = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [7:0] req_a_time,
    input  logic       req_b,
    input  logic [7:0] req_b_time,
    input  logic       ball_sense,
    input  logic       charge_done,
    input  logic       clear_fault,
    output logic       charge_en,
    output logic       kickstart,
    output logic [7:0] kicktime,
    output logic       ack_a,
    output logic       ack_b,
    output logic       ready,
    output logic       fault
);

    localparam int unsigned PW  = $clog2(TICK_DIV);
    localparam int unsigned MSW = 16;
    localparam int unsigned HW  = $clog2(KS_HOLD + 1);

    localparam logic [PW-1:0]  PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [MSW-1:0] TIMEOUT_LAST = MSW'(CHARGE_TIMEOUT - 1);
    localparam logic [MSW-1:0] COOL_LAST    = MSW'(COOLDOWN_MS - 1);
    localparam logic [MSW-1:0] MS_MAX       = '1;
    localparam logic [HW-1:0]  HOLD_LAST    = HW'(KS_HOLD - 1);

    typedef enum logic [2:0] {
        S_CHARGE,
        S_READY,
        S_FIRE,
        S_COOLDOWN,
        S_FAULT
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [MSW-1:0] ms_q, ms_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [7:0]     kicktime_q, kicktime_d;
    logic           charge_en_q, charge_en_d;
    logic           kickstart_q, kickstart_d;
    logic           ack_a_q, ack_a_d;
    logic           ack_b_q, ack_b_d;
    logic           ready_q, ready_d;
    logic           fault_q, fault_d;

    logic           tick;
    logic           entering;
    logic           a_ok;
    logic           b_ok;
    logic [MSW-1:0] ms_inc;

    always_comb begin
        state_d    = state_q;
        kicktime_d = kicktime_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;

        tick   = (presc_q == PRESC_LAST);
        ms_inc = (ms_q == MS_MAX) ? ms_q : ms_q + MSW'(1);
        // A level still high during its own ack cycle is the request just consumed.
        a_ok   = req_a && !ack_a_q;
        b_ok   = req_b && ball_sense && !ack_b_q;

        case (state_q)
            S_CHARGE: begin
                if (charge_done) begin
                    state_d = S_READY;
                end else if (tick && (ms_q >= TIMEOUT_LAST)) begin
                    state_d = S_FAULT;
                end
            end
            S_READY: begin
                if (a_ok) begin
                    ack_a_d    = 1'b1;
                    kicktime_d = req_a_time;
                    if (req_a_time != 8'd0) state_d = S_FIRE;
                end else if (b_ok) begin
                    ack_b_d    = 1'b1;
                    kicktime_d = req_b_time;
                    if (req_b_time != 8'd0) state_d = S_FIRE;
                end else if (!charge_done) begin
                    state_d = S_CHARGE;
                end
            end
            S_FIRE: begin
                if (hold_q == HOLD_LAST) state_d = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (tick && (ms_q >= COOL_LAST)) state_d = S_CHARGE;
            end
            S_FAULT: begin
                if (clear_fault) state_d = S_CHARGE;
            end
            default: state_d = S_CHARGE;
        endcase

        if ((state_d == S_COOLDOWN) && (state_q != S_COOLDOWN)) kicktime_d = 8'd0;

        // Timebase and ms count restart on every state entry.
        entering = (state_d != state_q);
        presc_d  = (entering || tick) ? '0 : presc_q + PW'(1);
        ms_d     = entering ? '0 : (tick ? ms_inc : ms_q);
        hold_d   = ((state_q == S_FIRE) && (state_d == S_FIRE)) ? hold_q + HW'(1) : '0;

        charge_en_d = (state_d == S_CHARGE) || (state_d == S_READY);
        kickstart_d = (state_d == S_FIRE);
        ready_d     = (state_d == S_READY);
        fault_d     = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CHARGE;
            presc_q     <= '0;
            ms_q        <= '0;
            hold_q      <= '0;
            kicktime_q  <= 8'd0;
            charge_en_q <= 1'b0;
            kickstart_q <= 1'b0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            ms_q        <= ms_d;
            hold_q      <= hold_d;
            kicktime_q  <= kicktime_d;
            charge_en_q <= charge_en_d;
            kickstart_q <= kickstart_d;
            ack_a_q     <= ack_a_d;
            ack_b_q     <= ack_b_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign charge_en = charge_en_q;
    assign kickstart = kickstart_q;
    assign kicktime  = kicktime_q;
    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign ready     = ready_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_kick_scheduler.sv
// Directed bench for kick_scheduler with a short timebase (4 clk/ms, timeout 10 ms,
// cooldown 5 ms, 3-cycle kickstart). Inputs change and outputs are sampled on negedge.
module tb_kick_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a;
    logic [7:0] req_a_time;
    logic       req_b;
    logic [7:0] req_b_time;
    logic       ball_sense;
    logic       charge_done;
    logic       clear_fault;
    logic       charge_en;
    logic       kickstart;
    logic [7:0] kicktime;
    logic       ack_a;
    logic       ack_b;
    logic       ready;
    logic       fault;

    int ntests = 0;
    int nfail  = 0;
    int cnt;
    int acks_a;
    int acks_b;

    kick_scheduler #(
        .TICK_DIV      (4),
        .CHARGE_TIMEOUT(10),
        .COOLDOWN_MS   (5),
        .KS_HOLD       (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .req_a_time (req_a_time),
        .req_b      (req_b),
        .req_b_time (req_b_time),
        .ball_sense (ball_sense),
        .charge_done(charge_done),
        .clear_fault(clear_fault),
        .charge_en  (charge_en),
        .kickstart  (kickstart),
        .kicktime   (kicktime),
        .ack_a      (ack_a),
        .ack_b      (ack_b),
        .ready      (ready),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_a = 1'b0; req_a_time = 8'd0; req_b = 1'b0; req_b_time = 8'd0;
        ball_sense = 1'b0; charge_done = 1'b0; clear_fault = 1'b0;

        // Reset state
        cyc(1);
        chk("rst_charge_en", 32'(charge_en), 32'd0);
        chk("rst_kickstart", 32'(kickstart), 32'd0);
        chk("rst_kicktime",  32'(kicktime),  32'd0);
        chk("rst_ready_fault", 32'({ready, fault, ack_a, ack_b}), 32'd0);
        rst = 1'b0;

        // 1: charge_en from first cycle, ready the cycle after charge_done
        cyc(1);
        chk("t1_charge_en_c1", 32'(charge_en), 32'd1);
        chk("t1_ready_c1", 32'(ready), 32'd0);
        cyc(19);
        chk("t1_ready_before_done", 32'(ready), 32'd0);
        chk("t1_no_fault", 32'(fault), 32'd0);
        charge_done = 1'b1;
        cyc(1);
        chk("t1_ready", 32'(ready), 32'd1);
        chk("t1_topoff", 32'(charge_en), 32'd1);

        // 2: host kick, 3-cycle strobe, 20-cycle cooldown
        req_a = 1'b1; req_a_time = 8'h7F;
        cyc(1);
        chk("t2_ack_a", 32'(ack_a), 32'd1);
        chk("t2_ks1", 32'(kickstart), 32'd1);
        chk("t2_kt1", 32'(kicktime), 32'h7F);
        chk("t2_chg_off", 32'(charge_en), 32'd0);
        req_a = 1'b0;
        cyc(1);
        chk("t2_ack_a_pulse", 32'(ack_a), 32'd0);
        chk("t2_ks2", 32'(kickstart), 32'd1);
        cyc(1);
        chk("t2_ks3", 32'(kickstart), 32'd1);
        chk("t2_kt3", 32'(kicktime), 32'h7F);
        cyc(1);
        chk("t2_ks_end", 32'(kickstart), 32'd0);
        chk("t2_kt_clear", 32'(kicktime), 32'd0);
        chk("t2_cool_chg", 32'(charge_en), 32'd0);
        cnt = 0;
        while (charge_en !== 1'b1 && cnt < 100) begin cyc(1); cnt++; end
        chk("t2_cooldown_len", 32'(cnt), 32'd20);
        chk("t2_charge_not_ready", 32'(ready), 32'd0);
        cyc(1);
        chk("t2_ready_again", 32'(ready), 32'd1);

        // 3: A beats B; B gated by ball_sense
        req_a = 1'b1; req_a_time = 8'h11; req_b = 1'b1; req_b_time = 8'h22; ball_sense = 1'b1;
        cyc(1);
        chk("t3_ack_a", 32'(ack_a), 32'd1);
        chk("t3_no_ack_b", 32'(ack_b), 32'd0);
        chk("t3_kt_a", 32'(kicktime), 32'h11);
        req_a = 1'b0; ball_sense = 1'b0;
        acks_a = 0; acks_b = 0;
        for (int i = 0; i < 28; i++) begin
            cyc(1);
            if (ack_a === 1'b1) acks_a++;
            if (ack_b === 1'b1) acks_b++;
        end
        chk("t3_no_ack_b_wo_ball", 32'(acks_b), 32'd0);
        chk("t3_no_extra_ack_a", 32'(acks_a), 32'd0);
        chk("t3_ready_waiting", 32'(ready), 32'd1);
        ball_sense = 1'b1;
        cyc(1);
        chk("t3_ack_b", 32'(ack_b), 32'd1);
        chk("t3_kt_b", 32'(kicktime), 32'h22);
        chk("t3_ks_b", 32'(kickstart), 32'd1);
        req_b = 1'b0; ball_sense = 1'b0; charge_done = 1'b0;

        // 4: charge timeout after 40 cycles, sticky, cleared by pulse
        cnt = 0;
        while (charge_en !== 1'b1 && cnt < 100) begin cyc(1); cnt++; end
        chk("t4_fire_plus_cool", 32'(cnt), 32'd23);
        cnt = 0;
        while (fault !== 1'b1 && cnt < 100) begin cyc(1); cnt++; end
        chk("t4_timeout_len", 32'(cnt), 32'd40);
        chk("t4_fault_chg_off", 32'(charge_en), 32'd0);
        cyc(3);
        chk("t4_fault_sticky", 32'(fault), 32'd1);
        clear_fault = 1'b1;
        cyc(1);
        clear_fault = 1'b0;
        chk("t4_fault_cleared", 32'(fault), 32'd0);
        chk("t4_recharge", 32'(charge_en), 32'd1);

        // charge_done wins over timeout in the same cycle
        cyc(39);
        chk("t4_prio_still_charge", 32'({fault, ready}), 32'd0);
        charge_done = 1'b1;
        cyc(1);
        chk("t4_prio_ready", 32'(ready), 32'd1);
        chk("t4_prio_no_fault", 32'(fault), 32'd0);

        // 5: zero strength consumed without a kick
        req_a = 1'b1; req_a_time = 8'h00;
        cyc(1);
        chk("t5_ack_a", 32'(ack_a), 32'd1);
        chk("t5_no_kick", 32'(kickstart), 32'd0);
        chk("t5_stay_ready", 32'(ready), 32'd1);
        req_a = 1'b0;
        cyc(1);
        chk("t5_ack_once", 32'(ack_a), 32'd0);
        chk("t5_still_no_kick", 32'(kickstart), 32'd0);

        // charge_done drop in READY returns to CHARGE
        charge_done = 1'b0;
        cyc(1);
        chk("t5_drop_ready", 32'(ready), 32'd0);
        chk("t5_drop_charging", 32'(charge_en), 32'd1);
        charge_done = 1'b1;
        cyc(1);
        chk("t5_ready_back", 32'(ready), 32'd1);

        // 6: reset mid-FIRE
        req_a = 1'b1; req_a_time = 8'h55;
        cyc(1);
        chk("t6_fire1", 32'({kickstart, kicktime}), 32'h155);
        req_a = 1'b0;
        cyc(1);
        chk("t6_fire2", 32'(kickstart), 32'd1);
        rst = 1'b1;
        cyc(1);
        chk("t6_rst_ks", 32'(kickstart), 32'd0);
        chk("t6_rst_chg", 32'(charge_en), 32'd0);
        chk("t6_rst_kt", 32'(kicktime), 32'd0);
        rst = 1'b0;
        cyc(1);
        chk("t6_chg_after_rst", 32'(charge_en), 32'd1);
        chk("t6_ks_after_rst", 32'(kickstart), 32'd0);
        cyc(1);
        chk("t6_ready_after_rst", 32'(ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
